fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Sequential instruction-fetch front end: the stage that consumes next-PC values and turns them into instruction-memory reads.
- Holds the architectural PC and issues word reads over a req/ack handshake to instruction memory.
- Buffers returned instructions in a 2-entry queue for decode.
- Accepts redirects (branch/jump targets) from execute, flushing stale fetches.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset (MIPS text base)
QDEPTH, 2, instruction queue depth (fixed 2; parameter for package consistency only)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  read request to instruction memory
imem_addr  output  32  word-aligned read address, valid while imem_req=1
imem_ack  input  1  memory has returned data this cycle (only meaningful while imem_req=1)
imem_rdata  input  32  instruction word, valid with imem_ack
redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 00)
instr_valid  output  1  queue head valid
instr  output  32  queue head instruction
instr_pc  output  32  address of queue head instruction
instr_ready  input  1  decode accepts head when instr_valid=1

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). All state registered; rst_n low forces reset values immediately, regardless of clk.
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0, queue empty, instr_valid=0, instr=0, instr_pc=0.
- FSM states:
  - IDLE: no outstanding request.
  - BUSY: outstanding request, data wanted.
  - KILL: outstanding request, data to be discarded.
- imem_req=1 exactly when state is BUSY or KILL.
- Handshake rule: once imem_req rises, imem_req and imem_addr stay constant until the cycle imem_ack=1. At most one request outstanding.
- Issue condition, "space": count_next + 0 < 2, where count_next is the queue count after this cycle's push/pop.
  - Issue loads imem_addr<=pc and pc<=pc+4. The +4 uses the existing increment_PC instance.
  - Wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- IDLE -> BUSY: when space and no redirect. IDLE stays IDLE with redirect: pc<=redirect_pc & ~3.
- BUSY, ack, no redirect: push {imem_rdata, imem_addr} into the queue. If space after the push, reissue immediately (BUSY, next address); otherwise go to IDLE.
  - Back-to-back: 1 instruction/cycle when memory acks every cycle.
- BUSY, redirect, no ack: go to KILL, pc<=target, flush queue.
- BUSY, redirect and ack in the same cycle: discard the data, flush, pc<=target, go to IDLE. The request from the target issues on the next cycle.
- KILL, ack: discard the data and go to IDLE. Fetch from the target starts on the following edge if space.
- KILL, another redirect: stay in KILL and update pc to the newest target.
- Queue: 2-entry FIFO, head drives instr/instr_pc/instr_valid.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle allowed; count unchanged.
  - Push is never attempted when full, guaranteed by the issue condition.
- Flush (redirect) has priority over pop and push in the same cycle. instr_valid=0 the cycle after redirect.
- Latency: ack at edge n -> instr_valid=1 after edge n (registered). Redirect at edge n -> imem_addr=target after edge n+1 at the earliest.
- Reset mid-request: req drops immediately. Memory must tolerate an abandoned request.

Decomposition:
- Package mips_fetch_pkg holds:
  - fetch_state_t enum {IDLE, BUSY, KILL}
  - localparams INSTR_BYTES=4, ADDR_W=32, DEFAULT_RESET_PC
- One sub-module: fetch_queue, a 2-entry FIFO with push/pop/flush and count output.
- PC increment reuses the increment_PC module.

Test Plan:
- Reset, then memory acks every cycle with data=addr^32'hA5A5_0000, instr_ready=1:
  - addresses 0x00400000, 04, 08, ... one per cycle
  - instr_pc matches each address
- instr_ready=0, zero-latency ack:
  - exactly 2 instructions queue (0x00400000, 0x00400004)
  - imem_req drops to 0
  - releasing ready resumes at 0x00400008
- Redirect to 0x00401003 while a request is outstanding with 3-cycle ack latency:
  - old data discarded, queue empty
  - next imem_addr=0x00401000
  - no instruction from the old path reaches decode
- Redirect coincident with ack: data dropped; next request at the target on the following cycle.
- RESET_PC=32'hFFFF_FFF8, ack every cycle: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst_n low asynchronously while imem_req=1 mid-stream: outputs return to reset values before the next clk edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

    localparam int ADDR_W      = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    // Redirect targets are word addresses; the byte offset is dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO; entry 0 is always the head presented to decode.
module fetch_queue
    import mips_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0] push_pc,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_instr,
    output logic [ADDR_W-1:0] head_pc,
    output logic [1:0]        count
);

    logic [ADDR_W-1:0] instr_q [2];
    logic [ADDR_W-1:0] pc_q    [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        instr_q[0] <= push_instr;
                        pc_q[0]    <= push_pc;
                    end else begin
                        instr_q[1] <= push_instr;
                        pc_q[1]    <= push_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    instr_q[0] <= instr_q[1];
                    pc_q[0]    <= pc_q[1];
                    count      <= count - 2'd1;
                end
                // Simultaneous push/pop: head advances, new word lands behind it.
                2'b11: begin
                    if (count == 2'd1) begin
                        instr_q[0] <= push_instr;
                        pc_q[0]    <= push_pc;
                    end else begin
                        instr_q[0] <= instr_q[1];
                        pc_q[0]    <= pc_q[1];
                        instr_q[1] <= push_instr;
                        pc_q[1]    <= push_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_instr = instr_q[0];
    assign head_pc    = pc_q[0];

endmodule

// File: rtl/increment_PC.sv
// Program-counter incrementer; wraps silently at the top of the address space.
module increment_PC #(
    parameter int W    = 32,
    parameter int STEP = 4
) (
    input  logic [W-1:0] pc,
    output logic [W-1:0] pc_next
);

    assign pc_next = pc + W'(STEP);

endmodule

// File: rtl/fetch_unit.sv
// Sequential fetch front end: owns the PC, issues one outstanding imem read at a
// time, buffers returned words for decode and squashes stale fetches on redirect.
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [ADDR_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam logic [1:0] QD = 2'(QDEPTH);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [1:0]        q_count;
    logic [1:0]        count_next;
    logic              ack;
    logic              push;
    logic              pop;
    logic              space;

    increment_PC #(.W(ADDR_W), .STEP(INSTR_BYTES)) u_inc (
        .pc      (pc),
        .pc_next (pc_inc)
    );

    // Both handshakes are valid/ready style: imem transfers on imem_req && imem_ack
    // with req/addr held until then; decode transfers on instr_valid && instr_ready.
    assign ack        = imem_req && imem_ack;
    assign pop        = instr_valid && instr_ready;
    assign push       = (state == BUSY) && ack && !redirect_valid;
    assign target     = word_align(redirect_pc);
    assign count_next = redirect_valid ? 2'd0 : (q_count + {1'b0, push} - {1'b0, pop});
    assign space      = (count_next < QD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= target;
                    end else if (space) begin
                        state     <= BUSY;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                        pc        <= pc_inc;
                    end
                end
                BUSY: begin
                    if (redirect_valid) begin
                        pc <= target;
                        if (imem_ack) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state <= KILL;
                        end
                    end else if (imem_ack) begin
                        if (space) begin
                            imem_addr <= pc;
                            pc        <= pc_inc;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                // Wait out the abandoned request; its data never reaches the queue.
                KILL: begin
                    if (redirect_valid) begin
                        pc <= target;
                    end
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_instr (imem_rdata),
        .push_pc    (imem_addr),
        .head_valid (instr_valid),
        .head_instr (instr),
        .head_pc    (instr_pc),
        .count      (q_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, directed and random stimulus, and a
// program-order reference model checked by an independent monitor.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] SALT   = 32'hA5A5_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT 0 (default reset PC) ----------------
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    // ---------------- DUT 1 (wrap-around reset PC, always-ack memory) ----------------
    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        imem_ack_w;
    logic [31:0] imem_rdata_w;
    logic        redirect_valid_w;
    logic [31:0] redirect_pc_w;
    logic        instr_valid_w;
    logic [31:0] instr_w;
    logic [31:0] instr_pc_w;
    logic        instr_ready_w;

    assign imem_ack_w       = 1'b1;
    assign imem_rdata_w     = imem_addr_w ^ SALT;
    assign redirect_valid_w = 1'b0;
    assign redirect_pc_w    = '0;
    assign instr_ready_w    = 1'b1;

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req_w),
        .imem_addr      (imem_addr_w),
        .imem_ack       (imem_ack_w),
        .imem_rdata     (imem_rdata_w),
        .redirect_valid (redirect_valid_w),
        .redirect_pc    (redirect_pc_w),
        .instr_valid    (instr_valid_w),
        .instr          (instr_w),
        .instr_pc       (instr_pc_w),
        .instr_ready    (instr_ready_w)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- memory responder ----------------
    int mem_wait  = 0;
    int mem_lat   = 0;
    int lat_fixed = 0;
    bit lat_rand  = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!imem_req) begin
            imem_ack = 1'b0;
            mem_wait = 0;
        end else begin
            if (mem_wait == 0) mem_lat = lat_rand ? $urandom_range(0, 3) : lat_fixed;
            if (mem_wait == mem_lat) begin
                imem_ack = 1'b1;
                mem_wait = 0;
            end else begin
                imem_ack = 1'b0;
                mem_wait++;
            end
        end
        imem_rdata = imem_addr ^ SALT;
    end

    // ---------------- reference model + monitor ----------------
    // Decode must see consecutive words of the current path; a redirect starts a
    // new path at the aligned target. Requests to memory follow the same rule.
    logic [63:0] exp_q[$];
    logic [31:0] path_pc;
    logic [31:0] req_path;
    logic        prev_req, prev_ack, prev_redirect;
    logic [31:0] prev_addr;

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            exp_q.delete();
            path_pc       = RST_PC;
            req_path      = RST_PC;
            prev_req      = 1'b0;
            prev_ack      = 1'b0;
            prev_redirect = 1'b0;
            prev_addr     = '0;
        end else begin
            if (prev_req && !prev_ack) begin
                check("req_hold", {31'b0, imem_req}, 32'd1);
                check("addr_hold", imem_addr, prev_addr);
            end else if (imem_req) begin
                check("req_addr", imem_addr, req_path);
                req_path = req_path + 32'd4;
            end
            if (prev_redirect) check("valid_after_redirect", {31'b0, instr_valid}, 32'd0);
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    exp_q.push_back({path_pc ^ SALT, path_pc});
                    path_pc = path_pc + 32'd4;
                end
                e = exp_q.pop_front();
                check("instr_pc", instr_pc, e[31:0]);
                check("instr", instr, e[63:32]);
            end
            if (redirect_valid) begin
                exp_q.delete();
                path_pc  = redirect_pc & ~32'd3;
                req_path = redirect_pc & ~32'd3;
            end
            prev_req      = imem_req;
            prev_ack      = imem_ack;
            prev_addr     = imem_addr;
            prev_redirect = redirect_valid;
        end
    end

    // ---------------- wrap-around monitor (DUT 1) ----------------
    logic [31:0] wrap_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    int n_w = 0;
    int m_w = 0;

    always @(negedge clk) begin
        if (rst_n && n_w < 4 && imem_req_w) begin
            check("wrap_addr", imem_addr_w, wrap_exp[n_w]);
            n_w++;
        end
        if (rst_n && m_w < 4 && instr_valid_w) begin
            check("wrap_instr_pc", instr_pc_w, wrap_exp[m_w]);
            check("wrap_instr", instr_w, wrap_exp[m_w] ^ SALT);
            m_w++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int k;
        logic [31:0] old_addr;

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;

        #3;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_req_w", {31'b0, imem_req_w}, 32'd0);

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Streaming: ack every cycle, decode always ready -> one word per cycle.
        k = 0;
        do begin @(negedge clk); k++; end while (!instr_valid && k < 10);
        check("first_valid", {31'b0, instr_valid}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("stream_valid", {31'b0, instr_valid}, 32'd1);
            check("stream_req", {31'b0, imem_req}, 32'd1);
        end

        // Decode stalled: exactly two words buffer and fetch stops.
        instr_ready = 1'b0;
        do_reset();
        repeat (6) @(negedge clk);
        check("full_req", {31'b0, imem_req}, 32'd0);
        check("full_valid", {31'b0, instr_valid}, 32'd1);
        check("full_head_pc", instr_pc, 32'h0040_0000);
        @(posedge clk); #2 instr_ready = 1'b1;
        repeat (8) @(posedge clk);

        // Redirect during a slow outstanding request.
        lat_fixed = 3;
        #2;
        k = 0;
        while (!(imem_req && !imem_ack && mem_wait == 1) && k < 40) begin
            @(posedge clk); #2; k++;
        end
        check("wait_outstanding", {31'b0, (imem_req && !imem_ack && mem_wait == 1)}, 32'd1);
        old_addr = imem_addr;
        pulse_redirect(32'h0040_1003);
        k = 0;
        do begin @(negedge clk); k++; end while (!(imem_req && imem_addr != old_addr) && k < 15);
        check("redirect_target_addr", imem_addr, 32'h0040_1000);
        repeat (20) @(posedge clk);

        // Redirect in the same cycle as an ack.
        lat_fixed = 0;
        #2;
        k = 0;
        while (!(imem_req && imem_ack) && k < 40) begin
            @(posedge clk); #2; k++;
        end
        check("wait_ack", {31'b0, (imem_req && imem_ack)}, 32'd1);
        pulse_redirect(32'h0040_2008);
        @(negedge clk);
        check("coinc_req_gap", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        check("coinc_req", {31'b0, imem_req}, 32'd1);
        check("coinc_addr", imem_addr, 32'h0040_2008);
        repeat (6) @(posedge clk);

        // Random traffic: latency, back-pressure and redirects.
        lat_rand = 1'b1;
        #2;
        for (int i = 0; i < 1500; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
            @(posedge clk); #2;
        end
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;

        // Asynchronous reset while a request is outstanding.
        lat_rand  = 1'b0;
        lat_fixed = 0;
        k = 0;
        while (!imem_req && k < 40) begin
            @(posedge clk); #2; k++;
        end
        check("wait_req_before_reset", {31'b0, imem_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_req", {31'b0, imem_req}, 32'd0);
        check("async_addr", imem_addr, 32'd0);
        check("async_valid", {31'b0, instr_valid}, 32'd0);
        check("async_instr", instr, 32'd0);
        check("async_instr_pc", instr_pc, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("restart_addr", imem_addr, RST_PC);
        repeat (20) @(posedge clk);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
